// File: rtl/prog_ram_arbiter.sv
// 16x8 program RAM shared by the button bit-editor, CPU fetch and LED row scanner.
// Optional `PROG_RAM_EDIT_LOCK_EN adds run_lock, which refuses edits while the CPU runs.
module prog_ram_arbiter #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned BW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          edit_req,
    input  logic [AW-1:0] edit_addr,
    input  logic [BW-1:0] edit_bit,
    input  logic          edit_val,
    output logic          edit_ack,
    output logic          edit_err,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic [DW-1:0] disp_rdata,
`ifdef PROG_RAM_EDIT_LOCK_EN
    input  logic          run_lock,
`endif
    output logic          busy
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, READ, EDIT_RD, EDIT_WR} state_t;
    typedef enum logic {SIDE_CPU, SIDE_DISP} side_t;

    state_t        state;
    side_t         rr_last;
    side_t         owner_q;
    logic [AW-1:0] addr_q;
    logic [BW-1:0] bit_q;
    logic          val_q;
    logic          lock_q;
    logic [DW-1:0] word_q;
    logic [DW-1:0] mem [DEPTH];

    logic          edit_lock_c;
    logic          edit_vis_c;
    logic          cpu_vis_c;
    logic          disp_vis_c;
    logic          pick_disp_c;
    logic [DW-1:0] wr_word_c;

`ifdef PROG_RAM_EDIT_LOCK_EN
    assign edit_lock_c = run_lock;
`else
    assign edit_lock_c = 1'b0;
`endif

    // A requester still seeing its own ack is masked so it is never served twice.
    always_comb begin
        edit_vis_c  = edit_req & ~edit_ack;
        cpu_vis_c   = cpu_req & ~cpu_ack;
        disp_vis_c  = disp_req & ~disp_ack;
        pick_disp_c = disp_vis_c;
        if (cpu_vis_c && disp_vis_c) begin
            pick_disp_c = (rr_last == SIDE_CPU);
        end
        wr_word_c        = word_q;
        wr_word_c[bit_q] = val_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_last    <= SIDE_DISP;
            owner_q    <= SIDE_CPU;
            addr_q     <= '0;
            bit_q      <= '0;
            val_q      <= 1'b0;
            lock_q     <= 1'b0;
            word_q     <= '0;
            edit_ack   <= 1'b0;
            edit_err   <= 1'b0;
            cpu_ack    <= 1'b0;
            disp_ack   <= 1'b0;
            cpu_rdata  <= '0;
            disp_rdata <= '0;
            busy       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            edit_ack <= 1'b0;
            edit_err <= 1'b0;
            cpu_ack  <= 1'b0;
            disp_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (edit_vis_c) begin
                        addr_q <= edit_addr;
                        bit_q  <= edit_bit;
                        val_q  <= edit_val;
                        lock_q <= edit_lock_c;
                        state  <= edit_lock_c ? EDIT_WR : EDIT_RD;
                        busy   <= 1'b1;
                    end else if (cpu_vis_c || disp_vis_c) begin
                        owner_q <= pick_disp_c ? SIDE_DISP : SIDE_CPU;
                        addr_q  <= pick_disp_c ? disp_addr : cpu_addr;
                        if (cpu_vis_c && disp_vis_c) begin
                            rr_last <= pick_disp_c ? SIDE_DISP : SIDE_CPU;
                        end
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (owner_q == SIDE_DISP) begin
                        disp_rdata <= mem[addr_q];
                        disp_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= mem[addr_q];
                        cpu_ack   <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                EDIT_RD: begin
                    word_q <= mem[addr_q];
                    state  <= EDIT_WR;
                end
                EDIT_WR: begin
                    // A locked edit is acknowledged as refused and leaves the RAM untouched.
                    if (!lock_q) begin
                        mem[addr_q] <= wr_word_c;
                    end
                    edit_ack <= 1'b1;
                    edit_err <= lock_q;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ram_arbiter.sv
// Directed bench for prog_ram_arbiter; the lock steps run only with PROG_RAM_EDIT_LOCK_EN.
module tb_prog_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       edit_req;
    logic [3:0] edit_addr;
    logic [2:0] edit_bit;
    logic       edit_val;
    logic       edit_ack;
    logic       edit_err;
    logic       cpu_req;
    logic [3:0] cpu_addr;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       disp_req;
    logic [3:0] disp_addr;
    logic       disp_ack;
    logic [7:0] disp_rdata;
    logic       busy;
`ifdef PROG_RAM_EDIT_LOCK_EN
    logic       run_lock;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .edit_req  (edit_req),
        .edit_addr (edit_addr),
        .edit_bit  (edit_bit),
        .edit_val  (edit_val),
        .edit_ack  (edit_ack),
        .edit_err  (edit_err),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_ack  (disp_ack),
        .disp_rdata(disp_rdata),
`ifdef PROG_RAM_EDIT_LOCK_EN
        .run_lock  (run_lock),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit disp, input logic [3:0] a, input logic [7:0] exp, input string tag);
        if (disp) begin
            disp_req  = 1'b1;
            disp_addr = a;
        end else begin
            cpu_req  = 1'b1;
            cpu_addr = a;
        end
        tick();
        check({tag, "_grant_ack"}, 32'(disp ? disp_ack : cpu_ack), 32'h0);
        check({tag, "_grant_busy"}, 32'(busy), 32'h1);
        tick();
        check({tag, "_ack"}, 32'(disp ? disp_ack : cpu_ack), 32'h1);
        check({tag, "_rdata"}, 32'(disp ? disp_rdata : cpu_rdata), 32'(exp));
        check({tag, "_busy_done"}, 32'(busy), 32'h0);
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(disp ? disp_ack : cpu_ack), 32'h0);
    endtask

    task automatic do_edit(input logic [3:0] a, input logic [2:0] b, input logic v,
                           input int lat, input logic exp_err, input string tag);
        edit_req  = 1'b1;
        edit_addr = a;
        edit_bit  = b;
        edit_val  = v;
        for (int i = 1; i < lat; i++) begin
            tick();
            check({tag, "_early_ack"}, 32'(edit_ack), 32'h0);
        end
        tick();
        check({tag, "_ack"}, 32'(edit_ack), 32'h1);
        check({tag, "_err"}, 32'(edit_err), 32'(exp_err));
        edit_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(edit_ack), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        edit_req = 1'b0; edit_addr = '0; edit_bit = '0; edit_val = 1'b0;
        cpu_req = 1'b0;  cpu_addr = '0;
        disp_req = 1'b0; disp_addr = '0;
`ifdef PROG_RAM_EDIT_LOCK_EN
        run_lock = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_acks", 32'({edit_ack, cpu_ack, disp_ack, edit_err}), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_disp_rdata", 32'(disp_rdata), 32'h0);
        rst_n = 1'b1;

        // Idle with no requests.
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_acks", 32'({edit_ack, cpu_ack, disp_ack}), 32'h0);

        do_read(1'b1, 4'd3, 8'h00, "disp_a3");

        do_edit(4'd5, 3'd2, 1'b1, 3, 1'b0, "edit_a5b2s");
        do_read(1'b0, 4'd5, 8'h04, "cpu_a5_set");
        check("nonowner_disp_rdata", 32'(disp_rdata), 32'h0);
        do_edit(4'd15, 3'd7, 1'b1, 3, 1'b0, "edit_a15b7");
        do_read(1'b1, 4'd15, 8'h80, "disp_a15");
        check("nonowner_cpu_rdata", 32'(cpu_rdata), 32'h04);
        do_edit(4'd5, 3'd2, 1'b0, 3, 1'b0, "edit_a5b2c");
        do_read(1'b0, 4'd5, 8'h00, "cpu_a5_clr");
        do_edit(4'd0, 3'd3, 1'b1, 3, 1'b0, "edit_a0b3");

        // Tie between fetch and display: cpu first, then strict alternation.
        cpu_req = 1'b1;  cpu_addr = 4'd15;
        disp_req = 1'b1; disp_addr = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_cpu_ack_e%0d", i + 1), 32'(cpu_ack), 32'((i % 4) == 1));
            check($sformatf("rr_disp_ack_e%0d", i + 1), 32'(disp_ack), 32'((i % 4) == 3));
            if ((i % 4) == 1) check("rr_cpu_rdata", 32'(cpu_rdata), 32'h80);
            if ((i % 4) == 3) check("rr_disp_rdata", 32'(disp_rdata), 32'h08);
        end
        cpu_req = 1'b0;
        disp_req = 1'b0;
        tick();
        check("rr_after_acks", 32'({cpu_ack, disp_ack}), 32'h0);
        check("rr_after_busy", 32'(busy), 32'h0);

        // Edit arrives during a cpu READ with display pending: cpu, edit, then display.
        cpu_req = 1'b1; cpu_addr = 4'd15;
        tick();
        check("mix_e1", 32'({cpu_ack, edit_ack, disp_ack}), 32'b000);
        edit_req = 1'b1; edit_addr = 4'd7; edit_bit = 3'd1; edit_val = 1'b1;
        disp_req = 1'b1; disp_addr = 4'd7;
        tick();
        check("mix_e2", 32'({cpu_ack, edit_ack, disp_ack}), 32'b100);
        cpu_req = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            tick();
            check($sformatf("mix_e%0d", i), 32'({cpu_ack, edit_ack, disp_ack}),
                  (i == 5) ? 32'b010 : ((i == 7) ? 32'b001 : 32'b000));
            if (i == 5) edit_req = 1'b0;
        end
        check("mix_raw_rdata", 32'(disp_rdata), 32'h02);
        disp_req = 1'b0;
        tick();

        // Reset during EDIT_RD aborts the write.
        edit_req = 1'b1; edit_addr = 4'd7; edit_bit = 3'd7; edit_val = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        edit_req = 1'b0;
        tick();
        check("abort_rst_ack", 32'(edit_ack), 32'h0);
        check("abort_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        check("abort_post_ack", 32'(edit_ack), 32'h0);
        check("abort_post_busy", 32'(busy), 32'h0);
        do_read(1'b0, 4'd7, 8'h00, "abort_a7");
        do_read(1'b1, 4'd15, 8'h00, "rst_clr_a15");

`ifdef PROG_RAM_EDIT_LOCK_EN
        run_lock = 1'b1;
        do_edit(4'd1, 3'd0, 1'b1, 2, 1'b1, "lock_a1");
        run_lock = 1'b0;
        do_read(1'b0, 4'd1, 8'h00, "lock_a1_rd");
`endif
        do_edit(4'd1, 3'd0, 1'b1, 3, 1'b0, "edit_a1b0");
        do_read(1'b0, 4'd1, 8'h01, "edit_a1_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_ram_arbiter.md
Name: prog_ram_arbiter

Overview:
- Owns the 16 x 8-bit program RAM and shares its single access port among three requesters: the button bit-editor (read-modify-write), the CPU instruction fetch, and the LED-matrix row scanner.
- Sits between the button/cursor logic, the 4-bit CPU core and the 8x8 matrix driver. It replaces the direct, unsynchronised RAM accesses those blocks would otherwise make.
- Fixed priority: editor first. Round-robin between fetch and display.

Parameters:
AW, 4, RAM address width (depth 2**AW = 16)
DW, 8, RAM word width
BW, 3, bit-index width for editor (log2 DW)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
edit_req  in  1  editor request, held until edit_ack
edit_addr  in  AW  word to modify (row y)
edit_bit  in  BW  bit to modify (column x)
edit_val  in  1  new bit value (A button = 1, B button = 0)
edit_ack  out  1  one-cycle pulse, edit completed
edit_err  out  1  valid with edit_ack; 1 = edit refused
cpu_req  in  1  fetch request, held until cpu_ack
cpu_addr  in  AW  fetch address (PC)
cpu_ack  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  DW  fetched instruction, held until next cpu_ack
disp_req  in  1  scan request, held until disp_ack
disp_addr  in  AW  row word address
disp_ack  out  1  one-cycle pulse, disp_rdata valid
disp_rdata  out  DW  row pattern, held until next disp_ack
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE; all acks=0; edit_err=0; cpu_rdata=0; disp_rdata=0; busy=0; rr_last=DISP (fetch wins the first tie); all 16 RAM words cleared to 8'h00. Reset mid-operation aborts any in-flight access. A pending edit write is not performed.
- States: IDLE, READ, EDIT_RD, EDIT_WR.
- Handshake:
  - A requester holds req and its address/data stable until it sees ack=1.
  - The requester must drop req in the cycle after ack, or re-request.
  - In IDLE, a requester whose ack is currently 1 is masked for that cycle, so the same request is never served twice.
- Arbitration (IDLE only, one grant per IDLE cycle):
  - An edit_req wins over everything.
  - Otherwise, if only one of cpu_req or disp_req is set, that one wins.
  - If both are set, the one not equal to rr_last wins, and rr_last is updated to the winner.
  - Edit grants do not change rr_last.
- Grant edge: the owner, address, bit and value are latched.
- Read path: IDLE -(grant)-> READ -> IDLE.
  - On the READ edge, the owner's rdata is loaded with mem[addr] and the owner's ack is set to 1 for exactly one cycle.
  - Ack is visible 2 clock edges after the request is first sampled in IDLE.
  - The non-owner's rdata is unchanged.
- Edit path: IDLE -> EDIT_RD -> EDIT_WR -> IDLE.
  - EDIT_RD: word register <= mem[addr].
  - EDIT_WR: mem[addr] <= word with bit[edit_bit] replaced by edit_val; edit_ack=1 and edit_err=0 for one cycle.
  - Ack is visible 3 edges after sampling.
- Maximum wait: a fetch or display request waits at most for one in-progress access (≤3 cycles), plus any back-to-back edits, plus one access from the other round-robin side.
- Read-after-write: a read granted after edit_ack returns the new value. There is no bypass path; ordering comes from serialisation.
- Address wrap: addresses are AW bits. Address 15 is valid and there is no out-of-range case.
- Bit index: edit_bit 0..7 all valid. Bit 0 = word LSB (matrix column mapping is the driver's concern).
- No request in IDLE: stay in IDLE, busy=0, all acks 0.

Optional Feature:
- Macro: PROG_RAM_EDIT_LOCK_EN.
- Defined:
  - Adds input port run_lock (1 bit, after disp_rdata).
  - If run_lock=1 when an edit is granted in IDLE, the FSM goes to EDIT_WR without a write.
  - On that edge, edit_ack=1 and edit_err=1, and the RAM is unchanged. Latency is 2 edges.
  - run_lock is sampled only at grant. Changes mid-edit are ignored.
- Undefined: run_lock port absent; edit_err is constant 0.

Test Plan:
- Reset, then disp_req with addr 3 → disp_ack pulses 2 edges later, disp_rdata=8'h00, busy high for 1 cycle.
- edit_req addr 5, bit 2, val 1 → edit_ack after 3 edges, err 0. Then cpu_req addr 5 → cpu_rdata=8'h04. Then edit bit 2 val 0 → a read returns 8'h00.
- cpu_req and disp_req held high together for 4 grants → grants alternate cpu, disp, cpu, disp (cpu first after reset). Each ack is a single cycle and no request is served twice.
- edit_req arrives while a READ for cpu is in progress, with disp_req also pending → cpu finishes, then the edit is served, then disp. The disp wait is ≤5 cycles.
- Assert rst_n=0 during EDIT_RD of an edit setting addr 7 bit 7 → after reset, a read of addr 7 returns 8'h00, no edit_ack is seen, and state is IDLE.
- With PROG_RAM_EDIT_LOCK_EN and run_lock=1: edit addr 1 bit 0 val 1 → edit_ack with edit_err=1 after 2 edges, and a read of addr 1 returns 8'h00. With run_lock=0, the same edit → 8'h01.
